// File: rtl/label_table_ctrl.sv
// Label table sequencer: clears the table after reset, then arbitrates define writes against lookups.
// Optional LABEL_TABLE_CTRL_DEFCHK_EN tracks defined labels and flags lookups of undefined ones.
module label_table_ctrl #(
    parameter int LBIDWidth = 8,
    parameter int WR_BURST  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_done,
    input  logic                 wr_req,
    input  logic [LBIDWidth-1:0] wr_lbid,
    input  logic [5:0]           wr_typ,
    input  logic [15:0]          wr_base,
    input  logic [15:0]          wr_count,
    output logic                 wr_ack,
    input  logic                 rd_req,
    input  logic [LBIDWidth-1:0] rd_lbid,
    output logic                 rd_ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [5:0]           rsp_typ,
    output logic [15:0]          rsp_base,
    output logic [15:0]          rsp_count,
    output logic                 rsp_err,
    output logic [LBIDWidth-1:0] tbl_lbid,
    output logic [LBIDWidth-1:0] tbl_lbidw,
    output logic                 tbl_we,
    output logic [5:0]           tbl_typw,
    output logic [15:0]          tbl_basew,
    output logic [15:0]          tbl_countw,
    input  logic [5:0]           tbl_typ,
    input  logic [15:0]          tbl_base,
    input  logic [15:0]          tbl_count
);
    localparam int BW = $clog2(WR_BURST + 1);
    localparam logic [BW-1:0]        BURST_MAX = BW'(WR_BURST);
    localparam logic [LBIDWidth-1:0] LAST_ID   = '1;

    typedef enum logic [1:0] {INIT, IDLE, CAP, RSP} state_t;

    state_t               state;
    logic [LBIDWidth-1:0] sweep;
    logic [BW-1:0]        burst;
    logic                 cap_err;

    // Reads only start from IDLE; a pending read wins once writes have had WR_BURST grants.
    always_comb begin
        rd_ack = (state == IDLE) && rd_req && (!wr_req || burst == BURST_MAX);
        wr_ack = (state != INIT) && wr_req && !rd_ack;
    end

    assign tbl_we     = (state == INIT) || wr_ack;
    assign tbl_lbid   = rd_lbid;
    assign tbl_lbidw  = (state == INIT) ? sweep : wr_lbid;
    assign tbl_typw   = (state == INIT) ? '0 : wr_typ;
    assign tbl_basew  = (state == INIT) ? '0 : wr_base;
    assign tbl_countw = (state == INIT) ? '0 : wr_count;

`ifdef LABEL_TABLE_CTRL_DEFCHK_EN
    localparam int DEPTH = 2 ** LBIDWidth;
    logic [DEPTH-1:0] defined;
    logic             undef_q;

    // Definedness is sampled at read grant, so a later write cannot change this lookup's verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            defined <= '0;
            undef_q <= 1'b0;
        end else begin
            if (state == INIT)
                defined[sweep] <= 1'b0;
            else if (wr_ack)
                defined[wr_lbid] <= 1'b1;
            if (rd_ack)
                undef_q <= !defined[rd_lbid];
        end
    end
    assign cap_err = undef_q;
`else
    assign cap_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep     <= '0;
            burst     <= '0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_typ   <= '0;
            rsp_base  <= '0;
            rsp_count <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (wr_ack)
                burst <= !rd_req ? '0 : (burst == BURST_MAX) ? burst : burst + BW'(1);
            else if (rd_ack)
                burst <= '0;

            case (state)
                INIT: begin
                    sweep <= sweep + LBIDWidth'(1);
                    if (sweep == LAST_ID) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: if (rd_ack) state <= CAP;
                // Table read register holds through any write in this cycle.
                CAP: begin
                    rsp_typ   <= cap_err ? '0 : tbl_typ;
                    rsp_base  <= cap_err ? '0 : tbl_base;
                    rsp_count <= cap_err ? '0 : tbl_count;
                    rsp_err   <= cap_err;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_label_table_ctrl.sv
// Scoreboard bench for label_table_ctrl with a behavioural registered label table.
module tb_label_table_ctrl;
    localparam int LW = 4;

`ifdef LABEL_TABLE_CTRL_DEFCHK_EN
    localparam logic UNDEF_ERR = 1'b1;
`else
    localparam logic UNDEF_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_done;
    logic          wr_req, wr_ack, rd_req, rd_ack;
    logic [LW-1:0] wr_lbid, rd_lbid;
    logic [5:0]    wr_typ;
    logic [15:0]   wr_base, wr_count;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [5:0]    rsp_typ;
    logic [15:0]   rsp_base, rsp_count;
    logic [LW-1:0] tbl_lbid, tbl_lbidw;
    logic          tbl_we;
    logic [5:0]    tbl_typw, tbl_typ;
    logic [15:0]   tbl_basew, tbl_countw, tbl_base, tbl_count;

    typedef struct {
        logic [5:0]  typ;
        logic [15:0] base;
        logic [15:0] count;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    label_table_ctrl #(.LBIDWidth(LW), .WR_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .wr_req(wr_req), .wr_lbid(wr_lbid), .wr_typ(wr_typ), .wr_base(wr_base),
        .wr_count(wr_count), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_lbid(rd_lbid), .rd_ack(rd_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_typ(rsp_typ),
        .rsp_base(rsp_base), .rsp_count(rsp_count), .rsp_err(rsp_err),
        .tbl_lbid(tbl_lbid), .tbl_lbidw(tbl_lbidw), .tbl_we(tbl_we),
        .tbl_typw(tbl_typw), .tbl_basew(tbl_basew), .tbl_countw(tbl_countw),
        .tbl_typ(tbl_typ), .tbl_base(tbl_base), .tbl_count(tbl_count)
    );

    // Single-ported table: registered read, read register holds during writes.
    logic [5:0]  mem_typ   [2**LW];
    logic [15:0] mem_base  [2**LW];
    logic [15:0] mem_count [2**LW];
    always @(posedge clk) begin
        if (tbl_we) begin
            mem_typ[tbl_lbidw]   <= tbl_typw;
            mem_base[tbl_lbidw]  <= tbl_basew;
            mem_count[tbl_lbidw] <= tbl_countw;
        end else begin
            tbl_typ   <= mem_typ[tbl_lbid];
            tbl_base  <= mem_base[tbl_lbid];
            tbl_count <= mem_count[tbl_lbid];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] t, input logic [15:0] b,
                                input logic [15:0] c, input logic e);
        exp_t r;
        r.typ = t; r.base = b; r.count = c; r.err = e;
        return r;
    endfunction

    // Monitor: every response handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got typ=%0h with empty scoreboard", rsp_typ);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_typ",   32'(rsp_typ),   32'(mon_e.typ));
                chk("rsp_base",  32'(rsp_base),  32'(mon_e.base));
                chk("rsp_count", 32'(rsp_count), 32'(mon_e.count));
                chk("rsp_err",   32'(rsp_err),   32'(mon_e.err));
            end
        end
    end

    task automatic wait_ack(input bit is_rd, input string name);
        int n = 0;
        @(negedge clk);
        while (!(is_rd ? rd_ack : wr_ack) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(is_rd ? rd_ack : wr_ack)) begin
            errors++;
            $display("FAIL %s_timeout: got no ack expected ack within 200 cycles", name);
        end
    endtask

    task automatic do_write(input logic [LW-1:0] id, input logic [5:0] t,
                            input logic [15:0] b, input logic [15:0] c);
        @(posedge clk); #1;
        wr_req = 1'b1; wr_lbid = id; wr_typ = t; wr_base = b; wr_count = c;
        wait_ack(1'b0, "wr_ack");
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    // Leaves the caller at the negedge of the cycle where the response first appears.
    task automatic do_read(input logic [LW-1:0] id, input logic [5:0] t,
                           input logic [15:0] b, input logic [15:0] c, input logic e);
        @(posedge clk); #1;
        sb.push_back(mk(t, b, c, e));
        rd_req = 1'b1; rd_lbid = id;
        wait_ack(1'b1, "rd_ack");
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300us");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_rd;
        rst_n = 1'b0; rsp_ready = 1'b1;
        wr_req = 1'b0; wr_lbid = '0; wr_typ = '0; wr_base = '0; wr_count = '0;
        rd_req = 1'b0; rd_lbid = '0;

        // Reset state, then the clear sweep with both requesters knocking
        repeat (3) @(negedge clk);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_typ",   32'(rsp_typ),   32'd0);
        chk("rst_tbl_we",    32'(tbl_we),    32'd1);
        rd_req = 1'b1; rd_lbid = 4'd2;
        wr_req = 1'b1; wr_lbid = 4'd1; wr_typ = 6'h3f;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("init_we",      32'(tbl_we),     32'd1);
            chk("init_lbidw",   32'(tbl_lbidw),  32'(i));
            chk("init_typw",    32'(tbl_typw),   32'd0);
            chk("init_no_rack", 32'(rd_ack),     32'd0);
            chk("init_no_wack", 32'(wr_ack),     32'd0);
            chk("init_not_done", 32'(init_done), 32'd0);
            if (i == 15) begin
                rd_req = 1'b0; wr_req = 1'b0;
            end
            @(negedge clk);
        end
        chk("init_done", 32'(init_done), 32'd1);
        chk("idle_we",   32'(tbl_we),    32'd0);

        // Define then look up lbid 3, stalled for 5 cycles
        do_write(4'd3, 6'h05, 16'h0100, 16'h0020);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_read(4'd3, 6'h05, 16'h0100, 16'h0020, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_typ",   32'(rsp_typ),   32'h05);
            chk("stall_base",  32'(rsp_base),  32'h0100);
            chk("stall_count", 32'(rsp_count), 32'h0020);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();

        // Write burst limit: 4 writes, then the pending read, then writes resume
        @(posedge clk); #1;
        wr_req = 1'b1; wr_lbid = 4'd10; wr_typ = 6'h02; wr_base = 16'h0aaa; wr_count = 16'h0001;
        rd_req = 1'b1; rd_lbid = 4'd5;
        sb.push_back(mk(6'h0, 16'h0, 16'h0, UNDEF_ERR));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("burst_wack", 32'(wr_ack), 32'(i != 4));
            chk("burst_rack", 32'(rd_ack), 32'(i == 4));
            got_rd = rd_ack;
            @(posedge clk); #1;
            if (got_rd) rd_req = 1'b0;
        end
        wr_req = 1'b0;
        drain();

        // Read-before-write: write to lbid 7 granted in the cycle after the read grant
        @(posedge clk); #1;
        sb.push_back(mk(6'h0, 16'h0, 16'h0, UNDEF_ERR));
        rd_req = 1'b1; rd_lbid = 4'd7;
        wait_ack(1'b1, "rbw_rd_ack");
        @(posedge clk); #1;
        rd_req = 1'b0;
        wr_req = 1'b1; wr_lbid = 4'd7; wr_typ = 6'h01; wr_base = 16'h0011; wr_count = 16'h0022;
        @(negedge clk);
        chk("rbw_wack_cap", 32'(wr_ack), 32'd1);
        @(posedge clk); #1;
        wr_req = 1'b0;
        drain();
        do_read(4'd7, 6'h01, 16'h0011, 16'h0022, 1'b0);
        drain();

        // Reset while a response is held
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        rd_req = 1'b1; rd_lbid = 4'd3;
        wait_ack(1'b1, "rstrsp_rd_ack");
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstrsp_valid_before", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstrsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("rstrsp_init_done",  32'(init_done), 32'd0);
        chk("rstrsp_we",         32'(tbl_we),    32'd1);
        chk("rstrsp_lbidw",      32'(tbl_lbidw), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        chk("resweep_lbidw0", 32'(tbl_lbidw), 32'd0);
        @(posedge clk); #1;
        chk("resweep_lbidw1", 32'(tbl_lbidw), 32'd1);
        begin
            int n = 0;
            while (!init_done && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        chk("resweep_done", 32'(init_done), 32'd1);

        // Undefined vs defined lookup of lbid 9 (table was cleared by the re-sweep)
        do_read(4'd9, 6'h00, 16'h0000, 16'h0000, UNDEF_ERR);
        drain();
        do_write(4'd9, 6'h2a, 16'h1234, 16'h0009);
        do_read(4'd9, 6'h2a, 16'h1234, 16'h0009, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
